// File: rtl/fifo_umbral_pkg.sv
// Shared widths, vector bit positions and threshold field offsets for the five buffer FIFOs.
package fifo_pkg;

  localparam int FIFO_DATA_W = 6;

  localparam int MF_ADDR_W  = 2;
  localparam int VC0_ADDR_W = 4;
  localparam int VC1_ADDR_W = 4;
  localparam int D0_ADDR_W  = 2;
  localparam int D1_ADDR_W  = 2;

  typedef enum logic [2:0] {
    BUF_D1  = 3'd0,
    BUF_D0  = 3'd1,
    BUF_VC1 = 3'd2,
    BUF_VC0 = 3'd3,
    BUF_MF  = 3'd4
  } buf_id_e;

  localparam int NUM_FIFOS = 5;

  // Bit index of each buffer inside FIFO_empty[4:0] / FIFO_error[4:0]
  localparam int MF_IDX  = 4;
  localparam int VC0_IDX = 3;
  localparam int VC1_IDX = 2;
  localparam int D0_IDX  = 1;
  localparam int D1_IDX  = 0;

  localparam int UMBRALES_W  = 14;
  localparam int UMB_MF_LSB  = 12;
  localparam int UMB_MF_MSB  = 13;
  localparam int UMB_VC0_LSB = 8;
  localparam int UMB_VC0_MSB = 11;
  localparam int UMB_VC1_LSB = 4;
  localparam int UMB_VC1_MSB = 7;
  localparam int UMB_D0_LSB  = 2;
  localparam int UMB_D0_MSB  = 3;
  localparam int UMB_D1_LSB  = 0;
  localparam int UMB_D1_MSB  = 1;

endpackage

// File: rtl/fifo_umbral_mem_dp.sv
// Dual-port register array: synchronous write, registered read that holds when not enabled.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_W,
  parameter int ADDR_WIDTH = MF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-address read and write returns the old word, which is what a full push+pop needs
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with live almost-empty/almost-full thresholds and overflow/underflow error.
// FIFO_ERR_STICKY_EN: error latches until reset; otherwise it pulses once per offending cycle.
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_W,
  parameter int ADDR_WIDTH = MF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] umbral_AE,
  input  logic [ADDR_WIDTH-1:0] umbral_AF,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   fifo_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic                  push, pop, err_evt;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= {1'b0, umbral_AE});
  assign almost_full  = (count_q >= {1'b0, umbral_AF});
  assign fifo_count   = count_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push
  assign pop     = rd_en && !empty;
  assign push    = wr_en && (!full || pop);
  assign err_evt = (wr_en && !push) || (rd_en && !pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = pop;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
`ifdef FIFO_ERR_STICKY_EN
    error_d = error_q || err_evt;
`else
    error_d = err_evt;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign valid_out = valid_q;
  assign error     = error_q;

  fifo_mem_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n_i (reset),
    .we_i    (push && reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .re_i    (pop),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out)
  );

endmodule

// File: tb/tb_fifo_umbral.sv
// Scoreboard bench for fifo_umbral (depth 4): queue reference model, directed scenarios then random traffic.
module tb_fifo_umbral;

  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef FIFO_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, wr_en, rd_en;
  logic [DW-1:0] data_in;
  logic [AW-1:0] umbral_AE, umbral_AF;
  logic [DW-1:0] data_out;
  logic          valid_out, empty, full, almost_empty, almost_full, error;
  logic [AW:0]   fifo_count;

  always #5 clk = ~clk;

  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .umbral_AE    (umbral_AE),
    .umbral_AF    (umbral_AF),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .error        (error),
    .fifo_count   (fifo_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO contents, words expected on data_out, and expected registered outputs
  logic [DW-1:0] mdl_q[$];
  logic [DW-1:0] exp_out[$];
  bit            exp_valid = 1'b0;
  bit            exp_err   = 1'b0;
  bit            mon_en    = 1'b0;
  logic [DW-1:0] last_dout = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    int n;
    if (mon_en) begin
      n = mdl_q.size();
      chk("fifo_count", 32'(fifo_count), n);
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("almost_empty", 32'(almost_empty), 32'(n <= int'(umbral_AE)));
      chk("almost_full", 32'(almost_full), 32'(n >= int'(umbral_AF)));
      chk("error", 32'(error), 32'(exp_err));
      chk("valid_out", 32'(valid_out), 32'(exp_valid));
      if (valid_out === 1'b1) begin
        if (exp_out.size() == 0) begin
          chk("scoreboard_nonempty", 32'(exp_out.size()), 1);
        end else begin
          last_dout = exp_out.pop_front();
          chk("data_out", 32'(data_out), 32'(last_dout));
        end
      end else begin
        chk("data_out_hold", 32'(data_out), 32'(last_dout));
      end
    end
  end

  task automatic step(input bit rn, input bit w, input logic [DW-1:0] d, input bit r);
    bit pop_ok, push_ok, evt;
    reset   = rn;
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    @(posedge clk);
    if (!rn) begin
      mdl_q.delete();
      exp_out.delete();
      last_dout = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end else begin
      pop_ok  = r && (mdl_q.size() > 0);
      push_ok = w && ((mdl_q.size() < DEPTH) || pop_ok);
      evt     = (w && !push_ok) || (r && !pop_ok);
      if (pop_ok)  exp_out.push_back(mdl_q.pop_front());
      if (push_ok) mdl_q.push_back(d);
      exp_valid = pop_ok;
      exp_err   = STICKY ? (exp_err || evt) : evt;
    end
    mon_en = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    umbral_AE = 2'd1; umbral_AF = 2'd3;

    // Reset then idle
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Fill to full, crossing both thresholds, then drain in order
    step(1, 1, 6'h11, 0);
    step(1, 1, 6'h22, 0);
    step(1, 1, 6'h33, 0);
    step(1, 1, 6'h24, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    step(1, 0, 0, 0);

    // Overflow while full, then full push+pop
    for (int i = 0; i < 4; i++) step(1, 1, 6'(i + 1), 0);
    step(1, 1, 6'h3F, 0);
    step(1, 0, 0, 0);
    step(1, 1, 6'h05, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);

    // Underflow, then push+pop on empty
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    step(1, 1, 6'h0A, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);

    // Pointer wrap with interleaved pops, reset mid-stream, then fresh word
    step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 6'(6'h30 + i), 0);
      if (i % 2 == 1) step(1, 0, 0, 1);
    end
    step(1, 1, 6'h2A, 1);
    step(0, 1, 6'h15, 1);
    step(1, 1, 6'h1C, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);

    // Threshold corner: AF = 0 asserts almost_full on empty
    umbral_AE = 2'd0; umbral_AF = 2'd0;
    step(1, 0, 0, 0);
    umbral_AE = 2'd3; umbral_AF = 2'd2;
    step(1, 0, 0, 0);

    // Random traffic with drifting bias and thresholds
    for (int i = 0; i < 3000; i++) begin
      int wb, rb;
      if (i % 25 == 0) begin
        umbral_AE = 2'($urandom_range(0, 3));
        umbral_AF = 2'($urandom_range(0, 3));
      end
      wb = ((i / 200) % 2 == 0) ? 70 : 35;
      rb = 100 - wb;
      step(($urandom_range(0, 149) != 0),
           ($urandom_range(0, 99) < wb),
           6'($urandom),
           ($urandom_range(0, 99) < rb));
    end

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("scoreboard_drained", 32'(exp_out.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
